// File: rtl/gowin_bsram_pkg.sv
// Shared types and helpers for the Gowin block SRAM sim models.
// Used by the SP model and its DP/SDP siblings.
package gowin_bsram_pkg;

   localparam int BSRAM_BITS = 16384;
   localparam int AD_W       = 14;
   localparam int D_PORT_W   = 32;

   typedef enum logic {
      RM_BYPASS = 1'b0,
      RM_PIPE   = 1'b1
   } read_mode_e;

   typedef enum logic [1:0] {
      WM_NORMAL = 2'b00,
      WM_THRU   = 2'b01,
      WM_RBW    = 2'b10
   } write_mode_e;

   // Byte enables sit in the low address bits for 16/32-bit words.
   function automatic logic [D_PORT_W-1:0] be_mask(
      input int              width,
      input logic [AD_W-1:0] ad
   );
      logic [D_PORT_W-1:0] m;
      m = '0;
      for (int b = 0; b < 4; b++) begin
         if (width <= 8 ||
             (width == 16 && b < 2 && ad[b]) ||
             (width == 32 && ad[b]))
            m[b*8 +: 8] = 8'hFF;
      end
      return m;
   endfunction

endpackage

// File: rtl/sp_bsram_sim_if.sv
// Access bus of the single-port block SRAM model.
// Clock and reset stay outside as plain ports.
interface sp_bsram_sim_if;
   logic        CE;
   logic        OCE;
   logic        WRE;
   logic [13:0] AD;
   logic [31:0] DI;
   logic [2:0]  BLKSEL;
   logic [31:0] DO;

   modport master (
      output CE, OCE, WRE, AD, DI, BLKSEL,
      input  DO
   );

   modport slave (
      input  CE, OCE, WRE, AD, DI, BLKSEL,
      output DO
   );
endinterface

// File: rtl/bsram_out_stage.sv
// Read-data registers: first stage rd_q and output DO,
// bypass or OCE-gated pipeline, async active-low clear.
module bsram_out_stage
   import gowin_bsram_pkg::*;
#(
   parameter read_mode_e MODE = RM_BYPASS,
   parameter int         W    = 16
) (
   input  logic         CLK,
   input  logic         RESETN,
   input  logic         ld,
   input  logic         oce,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] rd_q;

   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         rd_q <= '0;
         q    <= '0;
      end else begin
         if (ld) rd_q <= d;
         // OCE alone moves rd_q to DO, whatever CE/BLKSEL do
         if (MODE == RM_PIPE) begin
            if (oce) q <= rd_q;
         end else if (ld) begin
            q <= d;
         end
      end
   end

endmodule

// File: rtl/sp_bsram_sim.sv
// Single-port 16 Kbit Gowin block SRAM behavioural model.
// Holds the array, address decode, byte merge and write-mode mux.
module sp_bsram_sim
   import gowin_bsram_pkg::*;
#(
   parameter int         BIT_WIDTH  = 16,
   parameter logic       READ_MODE  = 1'b0,
   parameter logic [1:0] WRITE_MODE = 2'b00,
   parameter logic [2:0] BLK_SEL    = 3'b000
) (
   input logic          CLK,
   input logic          RESETN,
   sp_bsram_sim_if.slave bus
);

   localparam int DEPTH = BSRAM_BITS / BIT_WIDTH;
   localparam int ABITS = $clog2(BIT_WIDTH);
   localparam int IW    = AD_W - ABITS;

   if (BIT_WIDTH != 1 && BIT_WIDTH != 2 &&
       BIT_WIDTH != 4 && BIT_WIDTH != 8 &&
       BIT_WIDTH != 16 && BIT_WIDTH != 32) begin : g_bad_width
      $fatal(1, "sp_bsram_sim: bad BIT_WIDTH %0d", BIT_WIDTH);
   end

   if (WRITE_MODE == 2'b11) begin : g_bad_wmode
      $fatal(1, "sp_bsram_sim: WRITE_MODE 2'b11 unsupported");
   end

   logic [BIT_WIDTH-1:0] mem [DEPTH];

   logic                 acc;
   logic                 ld;
   logic                 ad_x;
   logic [IW-1:0]        idx;
   logic [D_PORT_W-1:0]  be_full;
   logic [BIT_WIDTH-1:0] mask;
   logic [BIT_WIDTH-1:0] old_w;
   logic [BIT_WIDTH-1:0] new_w;
   logic [BIT_WIDTH-1:0] stage;
   logic [BIT_WIDTH-1:0] do_w;
   logic                 unused_bits;

   // Reset low masks every access, so mem cannot change under reset
   assign acc   = RESETN & bus.CE & (bus.BLKSEL == BLK_SEL);
   assign ad_x  = $isunknown(bus.AD);
   assign idx   = bus.AD[AD_W-1:ABITS];
   assign be_full = be_mask(BIT_WIDTH, bus.AD);
   assign mask  = be_full[BIT_WIDTH-1:0];
   assign old_w = mem[idx];
   assign new_w = (old_w & ~mask) |
                  (bus.DI[BIT_WIDTH-1:0] & mask);

   assign unused_bits = ^{be_full, bus.DI};

   always_comb begin
      ld    = 1'b0;
      stage = old_w;
      unique case (1'b1)
         (acc && !bus.WRE): begin
            ld    = 1'b1;
            stage = old_w;
         end
         (acc && bus.WRE && WRITE_MODE == WM_THRU): begin
            ld    = 1'b1;
            stage = new_w;
         end
         (acc && bus.WRE && WRITE_MODE == WM_RBW): begin
            ld    = 1'b1;
            stage = old_w;
         end
         default: ;
      endcase
      if (acc && ad_x) begin
         ld    = 1'b1;
         stage = 'x;
      end
   end

   always_ff @(posedge CLK) begin
      if (acc && bus.WRE) begin
         if (ad_x)
            $warning("sp_bsram_sim: write to unknown address ignored");
         else
            mem[idx] <= new_w;
      end
   end

   bsram_out_stage #(
      .MODE (read_mode_e'(READ_MODE)),
      .W    (BIT_WIDTH)
   ) u_out (
      .CLK    (CLK),
      .RESETN (RESETN),
      .ld     (ld),
      .oce    (bus.OCE),
      .d      (stage),
      .q      (do_w)
   );

   assign bus.DO = D_PORT_W'(do_w);

endmodule

// File: tb/tb_sp_bsram_sim.sv
// Three SP BSRAM configs on one shared bus, scoreboarded
// against an array-based reference model.
module tb_sp_bsram_sim;

   logic CLK = 1'b0;
   logic RESETN = 1'b0;
   always #5 CLK = ~CLK;

   logic        ce, oce, wre;
   logic [13:0] ad;
   logic [31:0] di;
   logic [2:0]  blk;

   sp_bsram_sim_if ifa ();
   sp_bsram_sim_if ifb ();
   sp_bsram_sim_if ifc ();

   assign {ifa.CE, ifa.OCE, ifa.WRE, ifa.AD, ifa.DI, ifa.BLKSEL} =
          {ce, oce, wre, ad, di, blk};
   assign {ifb.CE, ifb.OCE, ifb.WRE, ifb.AD, ifb.DI, ifb.BLKSEL} =
          {ce, oce, wre, ad, di, blk};
   assign {ifc.CE, ifc.OCE, ifc.WRE, ifc.AD, ifc.DI, ifc.BLKSEL} =
          {ce, oce, wre, ad, di, blk};

   // a: 16b bypass normal; b: 32b pipeline RBW, block 2; c: 8b bypass write-through
   sp_bsram_sim #(
      .BIT_WIDTH(16), .READ_MODE(1'b0),
      .WRITE_MODE(2'b00), .BLK_SEL(3'd0)
   ) dut_a (.CLK(CLK), .RESETN(RESETN), .bus(ifa.slave));

   sp_bsram_sim #(
      .BIT_WIDTH(32), .READ_MODE(1'b1),
      .WRITE_MODE(2'b10), .BLK_SEL(3'd2)
   ) dut_b (.CLK(CLK), .RESETN(RESETN), .bus(ifb.slave));

   sp_bsram_sim #(
      .BIT_WIDTH(8), .READ_MODE(1'b0),
      .WRITE_MODE(2'b01), .BLK_SEL(3'd0)
   ) dut_c (.CLK(CLK), .RESETN(RESETN), .bus(ifc.slave));

   int         cw [3] = '{16, 32, 8};
   int         cab[3] = '{4, 5, 3};
   bit         crm[3] = '{1'b0, 1'b1, 1'b0};
   int         cwm[3] = '{0, 2, 1};
   logic [2:0] cbs[3] = '{3'd0, 3'd2, 3'd0};

   // Model memory with a per-word "fully written" flag (X until then)
   logic [31:0] mm[3][2048];
   bit          mk[3][2048];
   logic [31:0] m_do[3], m_rd[3];
   bit          k_do[3], k_rd[3];

   typedef struct packed {
      logic [2:0][31:0] v;
      logic [2:0]       kn;
   } exp_t;
   exp_t sb[$];

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 3; k++) begin
         m_do[k] = '0; m_rd[k] = '0;
         k_do[k] = 1'b1; k_rd[k] = 1'b1;
      end
   endtask

   task automatic model_edge();
      exp_t e;
      for (int k = 0; k < 3; k++) begin
         logic [31:0] old, nw, sv;
         bit ok, full, have, sk, en;
         int i;
         if (!RESETN) begin
            m_do[k] = '0; m_rd[k] = '0;
            k_do[k] = 1'b1; k_rd[k] = 1'b1;
         end else begin
            i    = int'(ad) >> cab[k];
            old  = mm[k][i];
            ok   = mk[k][i];
            have = 1'b0;
            sv   = '0;
            sk   = 1'b0;
            if (ce && blk == cbs[k]) begin
               if (!wre) begin
                  sv = old; sk = ok; have = 1'b1;
               end else begin
                  nw = old; full = 1'b1;
                  for (int b = 0; b < cw[k]; b++) begin
                     en = (cw[k] <= 8) || ad[b/8];
                     if (en) nw[b] = di[b];
                     else full = 1'b0;
                  end
                  mm[k][i] = nw;
                  mk[k][i] = ok || full;
                  if (cwm[k] == 1) begin
                     sv = nw; sk = ok || full; have = 1'b1;
                  end else if (cwm[k] == 2) begin
                     sv = old; sk = ok; have = 1'b1;
                  end
               end
            end
            if (crm[k]) begin
               if (oce) begin
                  m_do[k] = m_rd[k]; k_do[k] = k_rd[k];
               end
               if (have) begin
                  m_rd[k] = sv; k_rd[k] = sk;
               end
            end else if (have) begin
               m_do[k] = sv; k_do[k] = sk;
            end
         end
         e.v[k]  = m_do[k];
         e.kn[k] = k_do[k];
      end
      sb.push_back(e);
   endtask

   task automatic cyc(input logic c, input logic o, input logic w,
                      input logic [13:0] a, input logic [31:0] d,
                      input logic [2:0] b);
      ce = c; oce = o; wre = w; ad = a; di = d; blk = b;
      model_edge();
      @(posedge CLK);
      @(negedge CLK);
   endtask

   always @(posedge CLK) begin
      #1;
      if (sb.size() != 0) begin
         exp_t e;
         logic [31:0] act [3];
         e = sb.pop_front();
         act[0] = ifa.DO; act[1] = ifb.DO; act[2] = ifc.DO;
         for (int k = 0; k < 3; k++) begin
            if (e.kn[k]) begin
               n_chk++;
               if (act[k] !== e.v[k]) begin
                  n_fail++;
                  $display("FAIL sb_do%0d @%0t: got %h want %h",
                           k, $time, act[k], e.v[k]);
               end
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int r;
      logic [13:0] ra;
      logic [2:0]  rb;
      for (int k = 0; k < 3; k++)
         for (int i = 0; i < 2048; i++) begin
            mm[k][i] = '0; mk[k][i] = 1'b0;
         end
      model_reset();
      ce = 0; oce = 0; wre = 0; ad = '0; di = '0; blk = '0;

      cyc(0, 0, 0, 14'h0, 32'h0, 3'd0);
      cyc(1, 1, 0, 14'h0, 32'h0, 3'd0);
      RESETN = 1'b1;

      cyc(1, 1, 1, 14'h53, 32'hBEEF, 3'd0);
      cyc(1, 1, 0, 14'h53, 32'h0, 3'd0);
      chk("a_beef", ifa.DO, 32'hBEEF);

      cyc(1, 1, 1, 14'h6F, 32'h11223344, 3'd2);
      cyc(1, 1, 1, 14'h61, 32'h000000AA, 3'd2);
      cyc(1, 1, 0, 14'h60, 32'h0, 3'd2);
      cyc(0, 1, 0, 14'h0, 32'h0, 3'd2);
      chk("b_pipe", ifb.DO, 32'h112233AA);

      cyc(1, 1, 1, 14'h6F, 32'h000000C3, 3'd2);
      cyc(0, 1, 0, 14'h0, 32'h0, 3'd2);
      chk("b_rbw", ifb.DO, 32'h112233AA);
      cyc(1, 1, 0, 14'h60, 32'h0, 3'd2);
      cyc(0, 1, 0, 14'h0, 32'h0, 3'd2);
      chk("b_mem", ifb.DO, 32'h000000C3);

      cyc(1, 1, 1, 14'h38, 32'h5A, 3'd0);
      chk("c_wt1", ifc.DO, 32'h5A);
      cyc(1, 1, 1, 14'h38, 32'hC3, 3'd0);
      chk("c_wt2", ifc.DO, 32'hC3);
      chk("a_be0_hold", ifa.DO, 32'hBEEF);

      for (int i = 0; i < 6; i++)
         cyc(1, 1, 1'(i % 2), 14'h38 + 14'(i), $urandom(), 3'd1);
      chk("blk_a", ifa.DO, 32'hBEEF);
      chk("blk_b", ifb.DO, 32'hC3);
      chk("blk_c", ifc.DO, 32'hC3);

      cyc(1, 1, 1, 14'h8F, 32'hCAFEF00D, 3'd2);
      cyc(1, 0, 0, 14'h80, 32'h0, 3'd2);
      cyc(0, 0, 0, 14'h0, 32'h0, 3'd2);
      chk("b_oce_frz", ifb.DO, 32'hC3);
      cyc(0, 1, 0, 14'h0, 32'h0, 3'd2);
      chk("b_oce_rel", ifb.DO, 32'hCAFEF00D);

      cyc(1, 1, 1, 14'h93, 32'h1234, 3'd0);
      cyc(1, 1, 0, 14'h93, 32'h0, 3'd0);
      chk("a_1234", ifa.DO, 32'h1234);
      #2 RESETN = 1'b0;
      #1;
      chk("rst_a", ifa.DO, 32'h0);
      chk("rst_b", ifb.DO, 32'h0);
      chk("rst_c", ifc.DO, 32'h0);
      model_reset();
      cyc(1, 1, 1, 14'h53, 32'h0, 3'd0);
      RESETN = 1'b1;
      cyc(1, 1, 0, 14'h93, 32'h0, 3'd0);
      chk("a_post_rst", ifa.DO, 32'h1234);
      cyc(1, 1, 0, 14'h53, 32'h0, 3'd0);
      chk("a_mem_kept", ifa.DO, 32'hBEEF);

      for (int i = 0; i < 800; i++) begin
         ra = 14'($urandom_range(0, 255));
         if ($urandom_range(0, 1) == 1) ra[3:0] = 4'hF;
         r = $urandom_range(0, 4);
         rb = (r < 2) ? 3'd0 : (r < 4) ? 3'd2 : 3'd1;
         cyc(1'($urandom_range(0, 7) != 0),
             1'($urandom_range(0, 3) != 0),
             1'($urandom_range(0, 1)),
             ra, $urandom(), rb);
      end

      chk("sb_empty", 32'(sb.size()), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
